// File: rtl/spdif_frame_sequencer.sv
// -----------------------------------------------------------------------------
// spdif_frame_sequencer
//
// Turns stereo PCM pairs from the I2S deserialiser into the ordered stream of
// S/PDIF subframes consumed by the BMC line encoder. It owns the 192-frame
// block counter, preamble choice (B/M/W), the V/U/C/P bits, and substitutes a
// muted frame (audio 0, V=1) when no sample pair is waiting.
//
// Optional feature: define SPDIF_SEQ_CSTAT_EN to drive C from CS_WORD for
// frames 0..31. Without it, C is always 0 and CS_WORD is ignored.
//
// Parameters:
//   SAMPLE_W  audio sample width (16..24), left-justified in the 24-bit field
//   CS_WORD   channel-status bits 0..31 (bits 32..191 are always 0)
//
// Ports:
//   pin_i2s_bclk_pll  clock, all logic on its rising edge
//   pin_creset        asynchronous active-low reset
//   enable            run request; low returns to IDLE on the next edge
//   smp_valid/ready   sample-pair handshake into the holding register
//   smp_left/right    left/right samples
//   enc_valid/ready   subframe handshake towards the BMC encoder
//   enc_pre           preamble: 00 B, 01 M, 10 W
//   enc_word          subframe time slots 4..31 {P,C,U,V,audio[23:0]}
//   frame_idx         frame number within the block, 0..191
//   underrun          one-cycle pulse when a muted frame is latched
// -----------------------------------------------------------------------------
module spdif_frame_sequencer #(
  parameter int          SAMPLE_W = 24,
  parameter logic [31:0] CS_WORD  = 32'h0000_0000
) (
  input  logic                pin_i2s_bclk_pll,
  input  logic                pin_creset,
  input  logic                enable,
  input  logic                smp_valid,
  output logic                smp_ready,
  input  logic [SAMPLE_W-1:0] smp_left,
  input  logic [SAMPLE_W-1:0] smp_right,
  output logic                enc_valid,
  input  logic                enc_ready,
  output logic [1:0]          enc_pre,
  output logic [27:0]         enc_word,
  output logic [7:0]          frame_idx,
  output logic                underrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_LEFT, ST_RIGHT} state_e;

  localparam logic [1:0] PRE_B      = 2'b00;
  localparam logic [1:0] PRE_M      = 2'b01;
  localparam logic [1:0] PRE_W      = 2'b10;
  localparam logic [7:0] LAST_FRAME = 8'd191;

  // Assemble a subframe: audio left-justified, U=0, P gives even parity.
  function automatic logic [27:0] build_word(input logic [SAMPLE_W-1:0] smp,
                                             input logic v, input logic c);
    logic [23:0] audio;
    audio      = 24'(smp) << (24 - SAMPLE_W);
    build_word = {^{c, 1'b0, v, audio}, c, 1'b0, v, audio};
  endfunction

  state_e                state_q, state_d;
  logic                  hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0]   hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0]   hold_r_q, hold_r_d;
  logic                  smp_ready_q, smp_ready_d;
  logic                  enc_valid_q, enc_valid_d;
  logic [1:0]            enc_pre_q, enc_pre_d;
  logic [27:0]           enc_word_q, enc_word_d;
  logic [27:0]           right_word_q, right_word_d;
  logic [7:0]            frame_idx_q, frame_idx_d;
  logic                  underrun_q, underrun_d;

  logic                  xfer;
  logic                  capture;
  logic                  do_latch;
  logic                  consume;
  logic [7:0]            latch_idx;
  logic                  latch_c;
  logic [SAMPLE_W-1:0]   latch_l;
  logic [SAMPLE_W-1:0]   latch_r;

`ifndef SPDIF_SEQ_CSTAT_EN
  logic unused_cs_word;
  assign unused_cs_word = ^CS_WORD;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    hold_full_d  = hold_full_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    enc_valid_d  = enc_valid_q;
    enc_pre_d    = enc_pre_q;
    enc_word_d   = enc_word_q;
    right_word_d = right_word_q;
    frame_idx_d  = frame_idx_q;
    underrun_d   = 1'b0;
    do_latch     = 1'b0;
    latch_idx    = 8'd0;

    xfer    = enc_valid_q & enc_ready;
    capture = smp_valid & smp_ready_q;

    if (!enable) begin
      // Dropping enable abandons any pending subframe; the held pair stays.
      state_d     = ST_IDLE;
      enc_valid_d = 1'b0;
      frame_idx_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          do_latch  = 1'b1;
          latch_idx = 8'd0;
        end
        ST_LEFT: begin
          if (xfer) begin
            state_d    = ST_RIGHT;
            enc_pre_d  = PRE_W;
            enc_word_d = right_word_q;
          end
        end
        ST_RIGHT: begin
          if (xfer) begin
            do_latch  = 1'b1;
            latch_idx = (frame_idx_q == LAST_FRAME) ? 8'd0 : frame_idx_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef SPDIF_SEQ_CSTAT_EN
    latch_c = (latch_idx < 8'd32) ? CS_WORD[latch_idx[4:0]] : 1'b0;
`else
    latch_c = 1'b0;
`endif

    // A pair captured this same cycle is not visible yet; it serves the next frame.
    consume = do_latch & hold_full_q;
    latch_l = hold_full_q ? hold_l_q : '0;
    latch_r = hold_full_q ? hold_r_q : '0;

    if (do_latch) begin
      state_d      = ST_LEFT;
      enc_valid_d  = 1'b1;
      frame_idx_d  = latch_idx;
      enc_pre_d    = (latch_idx == 8'd0) ? PRE_B : PRE_M;
      enc_word_d   = build_word(latch_l, ~hold_full_q, latch_c);
      right_word_d = build_word(latch_r, ~hold_full_q, latch_c);
      underrun_d   = ~hold_full_q;
    end

    if (capture) begin
      hold_l_d = smp_left;
      hold_r_d = smp_right;
    end
    hold_full_d = (hold_full_q & ~consume) | capture;
    smp_ready_d = ~hold_full_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: the holding data is reset too; it is small and keeps the outputs
  // deterministic from the first frame.
  always_ff @(posedge pin_i2s_bclk_pll or negedge pin_creset) begin
    if (!pin_creset) begin
      state_q      <= ST_IDLE;
      hold_full_q  <= 1'b0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      smp_ready_q  <= 1'b1;
      enc_valid_q  <= 1'b0;
      enc_pre_q    <= PRE_B;
      enc_word_q   <= '0;
      right_word_q <= '0;
      frame_idx_q  <= 8'd0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_full_q  <= hold_full_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      smp_ready_q  <= smp_ready_d;
      enc_valid_q  <= enc_valid_d;
      enc_pre_q    <= enc_pre_d;
      enc_word_q   <= enc_word_d;
      right_word_q <= right_word_d;
      frame_idx_q  <= frame_idx_d;
      underrun_q   <= underrun_d;
    end
  end

  assign smp_ready = smp_ready_q;
  assign enc_valid = enc_valid_q;
  assign enc_pre   = enc_pre_q;
  assign enc_word  = enc_word_q;
  assign frame_idx = frame_idx_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_spdif_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spdif_frame_sequencer
//
// Directed steps plus randomized traffic for spdif_frame_sequencer. A
// subframe-level reference model (a queue of expected subframes and a queue of
// held sample pairs) predicts the outputs after every clock edge.
// -----------------------------------------------------------------------------
module tb_spdif_frame_sequencer;

  localparam int          SW = 24;
  localparam logic [31:0] CS = 32'h0000_0005;

  localparam logic [1:0] P_B = 2'b00;
  localparam logic [1:0] P_M = 2'b01;
  localparam logic [1:0] P_W = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          smp_valid = 1'b0;
  logic          smp_ready;
  logic [SW-1:0] smp_left = '0;
  logic [SW-1:0] smp_right = '0;
  logic          enc_valid;
  logic          enc_ready = 1'b0;
  logic [1:0]    enc_pre;
  logic [27:0]   enc_word;
  logic [7:0]    frame_idx;
  logic          underrun;

  always #5 clk = ~clk;

  spdif_frame_sequencer #(.SAMPLE_W(SW), .CS_WORD(CS)) dut (
    .pin_i2s_bclk_pll (clk),
    .pin_creset       (rst_n),
    .enable           (enable),
    .smp_valid        (smp_valid),
    .smp_ready        (smp_ready),
    .smp_left         (smp_left),
    .smp_right        (smp_right),
    .enc_valid        (enc_valid),
    .enc_ready        (enc_ready),
    .enc_pre          (enc_pre),
    .enc_word         (enc_word),
    .frame_idx        (frame_idx),
    .underrun         (underrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  pre;
    logic [27:0] word;
  } sub_t;

  sub_t        exp_q[$];
  logic [47:0] held[$];
  int          frame = 0;
  logic        und_exp = 1'b0;
  int          b_seen = 0;
  int          und_seen = 0;

  function automatic logic [27:0] mk_word(input logic [SW-1:0] smp, input logic v, input int n);
    logic [23:0] audio;
    logic        c;
    int          ones;
    audio = 24'(smp) << (24 - SW);
    c = 1'b0;
`ifdef SPDIF_SEQ_CSTAT_EN
    if (n < 32) c = CS[n];
`endif
    ones = $countones(audio) + int'(v) + int'(c);
    return {1'((ones % 2)), c, 1'b0, v, audio};
  endfunction

  task automatic make_frame();
    logic [47:0] pair;
    logic        v;
    if (held.size() != 0) begin
      pair = held.pop_front();
      v = 1'b0;
    end else begin
      pair = '0;
      v = 1'b1;
      und_exp = 1'b1;
    end
    exp_q.push_back({(frame == 0) ? P_B : P_M, mk_word(pair[47:24], v, frame)});
    exp_q.push_back({P_W, mk_word(pair[23:0], v, frame)});
  endtask

  // Advance the model across one clock edge using the inputs as driven now.
  task automatic model_edge();
    bit   ready_m;
    sub_t s;
    ready_m = (held.size() == 0);
    und_exp = 1'b0;
    if (!enable) begin
      exp_q.delete();
      frame = 0;
    end else if (exp_q.size() == 0) begin
      frame = 0;
      make_frame();
    end else if (enc_ready) begin
      s = exp_q.pop_front();
      if (s.pre == P_B) b_seen++;
      if (exp_q.size() == 0) begin
        frame = (frame + 1) % 192;
        make_frame();
      end
    end
    if (smp_valid && ready_m) held.push_back({smp_left, smp_right});
  endtask

  task automatic check_outputs();
    check("smp_ready", 32'(smp_ready), 32'(held.size() == 0));
    check("enc_valid", 32'(enc_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("enc_pre", 32'(enc_pre), 32'(exp_q[0].pre));
      check("enc_word", 32'(enc_word), 32'(exp_q[0].word));
    end
    check("frame_idx", 32'(frame_idx), 32'(frame));
    check("underrun", 32'(underrun), 32'(und_exp));
    if (underrun) und_seen++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_enc_valid"}, 32'(enc_valid), 32'd0);
    check({tag, "_enc_pre"}, 32'(enc_pre), 32'd0);
    check({tag, "_enc_word"}, 32'(enc_word), 32'd0);
    check({tag, "_frame_idx"}, 32'(frame_idx), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_smp_ready"}, 32'(smp_ready), 32'd1);
  endtask

  logic [27:0] exp_left_w;
  logic [27:0] exp_right_w;
  logic [23:0] cnt;

  initial begin
    // Power-on reset.
    #12;
    check_reset_values("por");
    rst_n = 1'b1;

    // Directed pair: 0x123456 / 0xABCDEF held before enable rises.
`ifdef SPDIF_SEQ_CSTAT_EN
    exp_left_w  = 28'h4123456;
    exp_right_w = 28'h4ABCDEF;
`else
    exp_left_w  = 28'h8123456;
    exp_right_w = 28'h8ABCDEF;
`endif
    smp_valid = 1'b1;
    smp_left  = 24'h123456;
    smp_right = 24'hABCDEF;
    step();
    smp_valid = 1'b0;
    step();
    enable    = 1'b1;
    enc_ready = 1'b1;
    step();
    check("pair_left_pre", 32'(enc_pre), 32'(P_B));
    check("pair_left_word", 32'(enc_word), 32'(exp_left_w));
    step();
    check("pair_right_pre", 32'(enc_pre), 32'(P_W));
    check("pair_right_word", 32'(enc_word), 32'(exp_right_w));
    step();
    check("pair_frame_idx", 32'(frame_idx), 32'd1);

    // Asynchronous reset while a left subframe is stalled.
    enc_ready = 1'b0;
    step();
    check("stall_in_left", 32'(enc_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    exp_q.delete();
    held.delete();
    frame   = 0;
    und_exp = 1'b0;
    enable  = 1'b0;
    #1;
    rst_n = 1'b1;
    step();

    // Muted frames: no samples arriving.
    enable    = 1'b1;
    enc_ready = 1'b1;
    und_seen  = 0;
    repeat (12) step();
    check("mute_underruns", 32'(und_seen), 32'd6);
    check("mute_frame_idx", 32'(frame_idx), 32'd5);
    enable = 1'b0;
    step();

    // Full block with a continuous incrementing sample stream.
    cnt       = 24'd1;
    smp_valid = 1'b1;
    smp_left  = cnt;
    smp_right = ~cnt;
    step();
    enable   = 1'b1;
    und_seen = 0;
    b_seen   = 0;
    for (int i = 0; i < 386; i++) begin
      cnt       = cnt + 24'd1;
      smp_left  = cnt;
      smp_right = ~cnt;
      step();
    end
    check("block_b_count", 32'(b_seen), 32'd2);
    check("block_underruns", 32'(und_seen), 32'd0);
    check("block_wrap_idx", 32'(frame_idx), 32'd0);

    // Randomized handshakes, sample arrival and occasional enable drops.
    for (int i = 0; i < 800; i++) begin
      enc_ready = ($urandom_range(0, 3) == 0);
      smp_valid = ($urandom_range(0, 1) == 1);
      smp_left  = SW'($urandom);
      smp_right = SW'($urandom);
      enable    = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spdif_frame_sequencer.md
# spdif_frame_sequencer

Schedules stereo PCM samples from the I2S receiver into S/PDIF subframes for the BMC line encoder that drives `pin_opt1`. Owns the 192-frame block counter, preamble selection (B/M/W), validity, channel-status and parity bits, and substitutes a muted subframe when the receiver underruns. Sits between the I2S deserialiser and the BMC encoder in the `pin_i2s_bclk_pll` domain.

## Interface
- `SAMPLE_W`, 24: audio sample width, 16..24; left-justified into the 24-bit audio field.
- `CS_WORD`, 32'h0000_0000: channel-status bits 0..31; bits 32..191 are always 0.

Ports:
- `pin_i2s_bclk_pll`  in  1  system clock; all logic rises on its posedge.
- `pin_creset`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  run request; low forces IDLE.
- `smp_valid`  in  1  stereo pair available.
- `smp_ready`  out  1  holding register empty.
- `smp_left`  in  SAMPLE_W  left sample.
- `smp_right`  in  SAMPLE_W  right sample.
- `enc_valid`  out  1  subframe presented to encoder.
- `enc_ready`  in  1  encoder accepts subframe.
- `enc_pre`  out  2  preamble: 00 B, 01 M, 10 W.
- `enc_word`  out  28  subframe time slots 4..31.
- `frame_idx`  out  8  frame number within block, 0..191.
- `underrun`  out  1  one-cycle pulse per muted frame.

## Operation
- States: IDLE, LEFT, RIGHT.
- IDLE: `enc_valid`=0, `frame_idx`=0. Holding register is retained. If `enable`=1, latch the left word and go to LEFT.
- Holding register: captures `{smp_left,smp_right}` when `smp_valid && smp_ready`. `smp_ready` = !hold_full, registered. The pair is consumed when a left word is latched.
- Left-word latch happens on the IDLE→LEFT transition and on a RIGHT transfer.
  - hold_full: audio = hold data, V=0; clear hold_full.
  - Otherwise: audio = 0 for both channels, V=1, `underrun` pulses for 1 cycle.
  - A capture in the same cycle is not bypassed. It fills hold for the next frame.
- LEFT: `enc_pre` = B if `frame_idx`==0, else M. On transfer (`enc_valid && enc_ready`), go to RIGHT and present the right word with `enc_pre`=W.
- RIGHT: on transfer, advance `frame_idx` (191→0 wrap), latch the next left word and go to LEFT.
- `enc_word` fields:
  - [23:0] audio << (24−SAMPLE_W).
  - [24] V.
  - [25] U=0.
  - [26] C.
  - [27] P = even parity over [26:0].
- The C bit for both subframes of frame n is the channel-status bit n (see Configuration).
- `enable` deasserted: go to IDLE on the next edge, even mid-handshake. The pending subframe is dropped and `frame_idx` is cleared. The held pair is kept.
- Reset values:
  - `enc_valid`=0, `enc_pre`=00, `enc_word`=0.
  - `frame_idx`=0, `underrun`=0.
  - `smp_ready`=1, hold_full=0, state IDLE.

## Timing
- `enable` rising at edge k: `enc_valid`=1 from edge k+1 with the B-preamble left word.
- While `enc_valid`=1 and `enc_ready`=0, `enc_pre` and `enc_word` are stable.
- Back-to-back transfers are allowed at one subframe per cycle. The next subframe is presented the cycle after a transfer.
- `smp_ready` falls the cycle after capture. It rises the cycle after the left-word latch that consumes the pair.
- `underrun` is asserted in the same cycle the muted left word first appears.
- `frame_idx` updates on the edge of the right-subframe transfer and is visible with the following left word.

## Configuration
- `SPDIF_SEQ_CSTAT_EN` defined: C = `CS_WORD[frame_idx]` for `frame_idx` < 32, else 0.
- Not defined: C=0 always, `CS_WORD` is ignored, and parity is recomputed accordingly.

## Test plan
- Reset mid-LEFT with `enc_valid`=1 → all outputs go to their reset values immediately and asynchronously. `smp_ready`=1.
- SAMPLE_W=24, pair (0x123456, 0xABCDEF) held, `enable` rises, `enc_ready`=1 → two transfers:
  - First: B, word 0x0123456 plus P.
  - Second: W, audio 0xABCDEF.
  - P makes each word even-parity. `frame_idx`=1 after both.
- `smp_valid` held 1 with an incrementing counter, `enc_ready`=1 → 192 frames:
  - Preamble B only at frames 0 and 192.
  - `frame_idx` wraps 191→0.
  - No `underrun` pulses.
- `smp_valid`=0 with `enable`=1 → muted subframes with V=1 and audio 0. `underrun` pulses once per frame. `frame_idx` still advances.
- `enc_ready` toggled randomly 1:3 → `enc_word` and `enc_pre` never change while `enc_valid && !enc_ready`. No subframe is skipped or duplicated.
- `SPDIF_SEQ_CSTAT_EN` with `CS_WORD`=32'h0000_0005 → C=1 in frames 0 and 2 (both subframes) and 0 in all other frames. Without the macro, C=0 in every frame.
